// File: rtl/ip_msg_pkg.sv
// Shared IP message definitions used by the IP TX path.
package ip_msg_pkg;

  localparam int IP_ADDR_W     = 32;
  localparam int PAYLOAD_LEN_W = 16;
  localparam int PROTOCOL_W    = 8;
  localparam int TIMESTAMP_W   = 64;

  typedef struct packed {
    logic [IP_ADDR_W-1:0]     src_ip;
    logic [IP_ADDR_W-1:0]     dst_ip;
    logic [PAYLOAD_LEN_W-1:0] data_payload_len;
    logic [PROTOCOL_W-1:0]    protocol;
    logic [TIMESTAMP_W-1:0]   timestamp;
  } ip_tx_metadata_flit;

endpackage

// File: rtl/ip_tx_arbiter_pkg.sv
// Local definitions for the IP TX arbiter.
package ip_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    META,
    DATA
  } state_t;

endpackage

// File: rtl/ip_tx_arbiter_rr_select.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_select #(
  parameter int NUM_SRCS = 2,
  localparam int IDX_W = $clog2(NUM_SRCS)
) (
  input  logic [NUM_SRCS-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  output logic                grant_val,
  output logic [IDX_W-1:0]    grant_idx
);

  localparam int unsigned N = NUM_SRCS;

  int unsigned cand;

  always_comb begin
    grant_val = 1'b0;
    grant_idx = ptr;
    cand      = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(ptr) + i) % N;
      if (!grant_val && req[cand]) begin
        grant_val = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/ip_tx_arbiter.sv
// Round-robin arbiter sharing one IP TX metadata+payload path among NUM_SRCS sources.
module ip_tx_arbiter
  import ip_msg_pkg::*;
  import ip_tx_arbiter_pkg::*;
#(
  parameter int NUM_SRCS = 2,
  parameter int DATA_W   = 512,
  localparam int PADBYTES_W = $clog2(DATA_W/8),
  localparam int GRANT_W    = $clog2(NUM_SRCS)
) (
  input  logic                                 clk,
  input  logic                                 rst,

  input  logic [NUM_SRCS-1:0]                  src_ip_tx_meta_val,
  input  ip_tx_metadata_flit [NUM_SRCS-1:0]    src_ip_tx_meta,
  output logic [NUM_SRCS-1:0]                  src_ip_tx_meta_rdy,

  input  logic [NUM_SRCS-1:0]                  src_ip_tx_data_val,
  input  logic [NUM_SRCS-1:0][DATA_W-1:0]      src_ip_tx_data,
  input  logic [NUM_SRCS-1:0]                  src_ip_tx_data_last,
  input  logic [NUM_SRCS-1:0][PADBYTES_W-1:0]  src_ip_tx_data_padbytes,
  output logic [NUM_SRCS-1:0]                  src_ip_tx_data_rdy,

  output logic                                 dst_ip_tx_meta_val,
  output ip_tx_metadata_flit                   dst_ip_tx_meta,
  input  logic                                 dst_ip_tx_meta_rdy,

  output logic                                 dst_ip_tx_data_val,
  output logic [DATA_W-1:0]                    dst_ip_tx_data,
  output logic                                 dst_ip_tx_data_last,
  output logic [PADBYTES_W-1:0]                dst_ip_tx_data_padbytes,
  input  logic                                 dst_ip_tx_data_rdy,

  output logic [GRANT_W-1:0]                   grant_src
);

  state_t             state, state_next;
  logic [GRANT_W-1:0] grant, grant_next;
  logic [GRANT_W-1:0] rr_ptr, rr_ptr_next;
  logic [GRANT_W-1:0] grant_inc;
  logic [GRANT_W-1:0] sel_idx;
  logic               sel_val;

  rr_select #(.NUM_SRCS(NUM_SRCS)) u_rr_select (
    .req       (src_ip_tx_meta_val),
    .ptr       (rr_ptr),
    .grant_val (sel_val),
    .grant_idx (sel_idx)
  );

  // Explicit wrap keeps non-power-of-two source counts in range.
  assign grant_inc = (grant == GRANT_W'(NUM_SRCS-1)) ? '0 : grant + GRANT_W'(1);

  assign dst_ip_tx_meta          = src_ip_tx_meta[grant];
  assign dst_ip_tx_data          = src_ip_tx_data[grant];
  assign dst_ip_tx_data_last     = src_ip_tx_data_last[grant];
  assign dst_ip_tx_data_padbytes = src_ip_tx_data_padbytes[grant];
  assign grant_src               = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_next;
      grant  <= grant_next;
      rr_ptr <= rr_ptr_next;
    end
  end

  always_comb begin
    state_next         = state;
    grant_next         = grant;
    rr_ptr_next        = rr_ptr;
    dst_ip_tx_meta_val = 1'b0;
    dst_ip_tx_data_val = 1'b0;
    src_ip_tx_meta_rdy = '0;
    src_ip_tx_data_rdy = '0;
    case (state)
      IDLE: begin
        if (sel_val) begin
          grant_next = sel_idx;
          state_next = META;
        end
      end
      META: begin
        dst_ip_tx_meta_val        = src_ip_tx_meta_val[grant];
        src_ip_tx_meta_rdy[grant] = dst_ip_tx_meta_rdy;
        if (src_ip_tx_meta_val[grant] && dst_ip_tx_meta_rdy) begin
          if (src_ip_tx_meta[grant].data_payload_len != '0) begin
            state_next = DATA;
          end else begin
            state_next  = IDLE;
            rr_ptr_next = grant_inc;
          end
        end
      end
      DATA: begin
        dst_ip_tx_data_val        = src_ip_tx_data_val[grant];
        src_ip_tx_data_rdy[grant] = dst_ip_tx_data_rdy;
        if (src_ip_tx_data_val[grant] && dst_ip_tx_data_rdy && src_ip_tx_data_last[grant]) begin
          state_next  = IDLE;
          rr_ptr_next = grant_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/ip_tx_arbiter.md
IP_TX_ARBITER -- requirements
Module: ip_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRCS, default 2, number of requesters sharing the IP TX path (2..8).
REQ-002 SHALL have parameter DATA_W, default 512, data-flit width in bits; PADBYTES_W = clog2(DATA_W/8).
REQ-003 SHALL have port clk, input, 1, sole clock; one clock, all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port src_ip_tx_meta_val, input, NUM_SRCS, per-source metadata valid.
REQ-006 SHALL have port src_ip_tx_meta, input, NUM_SRCS x ip_tx_metadata_flit, per-source metadata (src_ip, dst_ip, data_payload_len, protocol, timestamp).
REQ-007 SHALL have port src_ip_tx_meta_rdy, output, NUM_SRCS, per-source metadata ready.
REQ-008 SHALL have port src_ip_tx_data_val, input, NUM_SRCS, per-source payload valid.
REQ-009 SHALL have port src_ip_tx_data, input, NUM_SRCS x DATA_W, payload flits.
REQ-010 SHALL have port src_ip_tx_data_last, input, NUM_SRCS, final payload flit.
REQ-011 SHALL have port src_ip_tx_data_padbytes, input, NUM_SRCS x PADBYTES_W, unused bytes in last flit.
REQ-012 SHALL have port src_ip_tx_data_rdy, output, NUM_SRCS, per-source payload ready.
REQ-013 SHALL have ports dst_ip_tx_meta_val (output, 1), dst_ip_tx_meta (output, ip_tx_metadata_flit) and dst_ip_tx_meta_rdy (input, 1), the shared metadata channel.
REQ-014 SHALL have ports dst_ip_tx_data_val (output, 1), dst_ip_tx_data (output, DATA_W), dst_ip_tx_data_last (output, 1), dst_ip_tx_data_padbytes (output, PADBYTES_W) and dst_ip_tx_data_rdy (input, 1), the shared payload channel.
REQ-015 SHALL have port grant_src, output, clog2(NUM_SRCS), index of the current owner (debug).

Function
REQ-016 SHALL implement FSM states IDLE, META and DATA.
REQ-017 In IDLE, if any src meta_val is set, SHALL select one source by round-robin starting at rr_ptr, register it in grant_src and enter META next cycle; request-to-dst_meta_val latency is 1 cycle.
REQ-018 In IDLE, all src rdy outputs and all dst val outputs SHALL be 0.
REQ-019 In META, dst_ip_tx_meta_val and dst_ip_tx_meta SHALL equal the granted source's inputs combinationally, and src_ip_tx_meta_rdy[grant] SHALL equal dst_ip_tx_meta_rdy.
REQ-020 On a meta handshake, SHALL enter DATA if data_payload_len != 0; otherwise SHALL return to IDLE and set rr_ptr = grant+1.
REQ-021 In DATA, dst data channel fields SHALL mirror the granted source, and src_ip_tx_data_rdy[grant] SHALL equal dst_ip_tx_data_rdy.
REQ-022 On a data handshake with last=1, SHALL return to IDLE and set rr_ptr = grant+1 modulo NUM_SRCS (NUM_SRCS-1 wraps to 0).
REQ-023 Non-granted sources SHALL see rdy=0 on both channels in every state; a grant SHALL NOT change until the packet completes.
REQ-024 Val SHALL NOT depend combinationally on rdy on any dst port; dst data_val SHALL NOT assert in META.
REQ-025 Source meta_val deasserting while in META SHALL hold the FSM in META (no timeout, no regrant).
REQ-026 A source requesting continuously SHALL be granted at most once before every other requesting source is granted once.
REQ-027 Minimum packet-to-packet gap SHALL be one IDLE cycle; one packet, meta plus data, is in flight at a time.

Reset
REQ-028 While rst is high, state SHALL be IDLE, rr_ptr = 0 and grant_src = 0, and all val/rdy outputs SHALL be 0 on the next edge.
REQ-029 rst asserted mid-packet SHALL abandon the packet with no completion flit emitted; after reset, the source restarts from metadata.

Structure
REQ-030 ip_tx_metadata_flit and the IP/length/protocol/timestamp widths SHALL come from the shared IP message package; the FSM state enum SHALL live in a local package (ip_tx_arbiter_pkg).
REQ-031 Round-robin selection SHALL be a sub-module, rr_select (inputs: req vector and ptr; outputs: grant_val and grant index), purely combinational.

Verification
REQ-032 Single source 0 sends meta len=100 plus 2 flits (padbytes=28) -> dst sees meta then 2 flits, last on the second, grant_src=0, returns to IDLE.
REQ-033 Sources 0 and 1 request together at reset -> grants in order 0,1,0,1 over 4 packets, and src_ip_tx_meta_rdy[1] stays 0 during packet 0.
REQ-034 dst_ip_tx_data_rdy toggles 1,0,1,0 during a 4-flit packet -> no flit lost or duplicated, no switch to a waiting source.
REQ-035 Meta with data_payload_len=0 -> FSM goes META to IDLE, dst_data_val never asserts, rr_ptr advances.
REQ-036 rst pulsed for 1 cycle after flit 1 of 3 -> all outputs 0 next cycle, FSM IDLE, and the next grant goes to source 0.
REQ-037 NUM_SRCS=4 with all sources requesting and grant at 3 -> the next grant is 0 (wrap).
